// File: rtl/data_plane_rx_if.sv
// Packet-bus / GPP-drain bundle for the data plane receiver.
interface data_plane_rx_if #(parameter int DEPTH = 16) ();
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [15:0]      node_id;
  logic [31:0]      data_rx_packet;
  logic             gpp_rd_dp;
  logic [15:0]      rx_data_out;
  logic [15:0]      rx_src_out;
  logic [CNT_W-1:0] rx_count;
  logic             rx_empty;
  logic             rx_full;
  logic             rx_done;
  logic             rx_drop;

  modport master (
    output node_id, data_rx_packet, gpp_rd_dp,
    input  rx_data_out, rx_src_out, rx_count, rx_empty, rx_full, rx_done, rx_drop
  );

  modport slave (
    input  node_id, data_rx_packet, gpp_rd_dp,
    output rx_data_out, rx_src_out, rx_count, rx_empty, rx_full, rx_done, rx_drop
  );
endinterface

// File: rtl/data_plane_rx.sv
// Data plane receiver: filters frames for this node and commits them whole into a {src,data} FIFO.
// Optional DP_RX_BROADCAST_EN: also accept frames addressed to 16'hFFFF.
module data_plane_rx #(
  parameter int DEPTH        = 16,
  parameter int PKT_DATA_LEN = 4
) (
  input logic            clk,
  input logic            rst,
  data_plane_rx_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int WC_W  = $clog2(PKT_DATA_LEN + 1);
  localparam logic [CNT_W-1:0] LEN_C   = CNT_W'(PKT_DATA_LEN);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [WC_W-1:0]  LAST_C  = WC_W'(PKT_DATA_LEN - 1);

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  state_t           state_q, state_d;
  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, tent_ptr;
  logic [WC_W-1:0]  word_cnt;
  logic [CNT_W-1:0] count_q;
  logic [15:0]      src_q;
  logic             done_q, drop_q;
  logic [15:0]      dest;
  logic             match, fits, pop;
  logic             capture, wr_en, commit, drop_set;
  logic [31:0]      head;

  assign dest = bus.data_rx_packet[31:16];
`ifdef DP_RX_BROADCAST_EN
  assign match = (bus.data_rx_packet != '0) && ((dest == bus.node_id) || (dest == 16'hFFFF));
`else
  assign match = (bus.data_rx_packet != '0) && (dest == bus.node_id);
`endif

  // Space check uses committed entries only; pops during RECV can only add room.
  assign fits = (DEPTH_C - count_q) >= LEN_C;
  assign pop  = bus.gpp_rd_dp && (count_q != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    wr_en    = 1'b0;
    commit   = 1'b0;
    drop_set = 1'b0;
    case (state_q)
      IDLE: if (match) begin
        capture = 1'b1;
        state_d = fits ? RECV : DROP;
      end
      RECV: if (match) begin
        wr_en = 1'b1;
        if (word_cnt == LAST_C) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end else begin
        drop_set = 1'b1;
        state_d  = IDLE;
      end
      DROP: if (!match || word_cnt == LAST_C) begin
        drop_set = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      tent_ptr <= '0;
      word_cnt <= '0;
      count_q  <= '0;
      src_q    <= '0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      done_q <= commit;
      drop_q <= drop_set;
      if (capture) begin
        src_q    <= bus.data_rx_packet[15:0];
        word_cnt <= '0;
        tent_ptr <= wr_ptr;
      end else if (state_q != IDLE && match) begin
        word_cnt <= word_cnt + 1'b1;
      end
      if (wr_en)  tent_ptr <= tent_ptr + 1'b1;
      if (commit) wr_ptr   <= tent_ptr + 1'b1;
      if (pop)    rd_ptr   <= rd_ptr + 1'b1;
      count_q <= count_q + (commit ? LEN_C : '0) - CNT_W'(pop);
    end
  end

  // Tentative writes land past wr_ptr, so they stay hidden until commit moves it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[tent_ptr] <= {src_q, bus.data_rx_packet[15:0]};
  end

  assign head            = mem[rd_ptr];
  assign bus.rx_empty    = (count_q == '0);
  assign bus.rx_full     = (count_q == DEPTH_C);
  assign bus.rx_count    = count_q;
  assign bus.rx_data_out = bus.rx_empty ? 16'h0 : head[15:0];
  assign bus.rx_src_out  = bus.rx_empty ? 16'h0 : head[31:16];
  assign bus.rx_done     = done_q;
  assign bus.rx_drop     = drop_q;
endmodule

// File: tb/tb_data_plane_rx.sv
// Randomized frame-level bench for data_plane_rx with a queue-based scoreboard.
module tb_data_plane_rx;
  localparam int DEPTH = 16;
  localparam int LEN   = 4;
  localparam logic [15:0] NODE = 16'h0003;

  logic clk = 1'b0;
  logic rst;

  data_plane_rx_if #(.DEPTH(DEPTH)) bus ();
  data_plane_rx #(.DEPTH(DEPTH), .PKT_DATA_LEN(LEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int          vectors = 0;
  int          errs    = 0;
  logic [31:0] q[$];          // committed {src,data} words the GPP has yet to pop
  bit          pop_pend = 1'b0;
  bit          exp_done = 1'b0;
  bit          exp_drop = 1'b0;
  bit          mon_en   = 1'b0;
  int          pop_pct  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] other_dest();
    logic [15:0] r;
    r = 16'($urandom_range(4, 65534));
    return r;
  endfunction

  // Monitor: compares DUT state to the scoreboard each cycle and issues random pops.
  initial begin
    bus.gpp_rd_dp = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (mon_en) begin
        pop_pend = 1'b0;
        chk("rx_count", 32'(bus.rx_count), 32'(q.size()));
        chk("rx_empty", 32'(bus.rx_empty), 32'(q.size() == 0));
        chk("rx_full",  32'(bus.rx_full),  32'(q.size() == DEPTH));
        chk("rx_done",  32'(bus.rx_done),  32'(exp_done));
        chk("rx_drop",  32'(bus.rx_drop),  32'(exp_drop));
        exp_done = 1'b0;
        exp_drop = 1'b0;
        if (q.size() > 0) chk("head", {bus.rx_src_out, bus.rx_data_out}, q[0]);
        else              chk("head_empty", {bus.rx_src_out, bus.rx_data_out}, 32'h0);
        bus.gpp_rd_dp = ($urandom_range(99) < pop_pct);
        if (bus.gpp_rd_dp && q.size() > 0) begin
          void'(q.pop_front());
          pop_pend = 1'b1;
        end
      end else begin
        bus.gpp_rd_dp = 1'b0;
      end
    end
  end

  task automatic drive(input logic [31:0] p);
    @(negedge clk);
    bus.data_rx_packet = p;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(32'h0);
  endtask

  // A frame either fully commits, is dropped whole, or (foreign) is invisible.
  task automatic send_frame(input bit to_us, input int nw, input logic [15:0] src,
                            input logic [LEN*16-1:0] dat, input bit term_foreign);
    logic [15:0] dst;
    bit fits;
    dst = to_us ? NODE : other_dest();
    @(negedge clk);
    fits = (DEPTH - (q.size() + int'(pop_pend))) >= LEN;
    bus.data_rx_packet = {dst, src};
    for (int i = 0; i < nw; i++) drive({dst, dat[i*16 +: 16]});
    if (!to_us) return;
    if (nw == LEN) begin
      @(posedge clk);
      if (fits) begin
        for (int i = 0; i < LEN; i++) q.push_back({src, dat[i*16 +: 16]});
        exp_done = 1'b1;
      end else begin
        exp_drop = 1'b1;
      end
    end else begin
      drive(term_foreign ? {other_dest(), 16'($urandom)} : 32'h0);
      @(posedge clk);
      exp_drop = 1'b1;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    pop_pct = 100;
    while (q.size() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    vectors++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain_timeout: %0d words left, expected 0", q.size());
    end
    pop_pct = 0;
  endtask

  function automatic logic [LEN*16-1:0] rand_dat();
    logic [LEN*16-1:0] d;
    for (int i = 0; i < LEN; i++) d[i*16 +: 16] = 16'($urandom);
    return d;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.node_id = NODE;
    bus.data_rx_packet = 32'h0;
    #2 rst = 1'b0;
    #1;
    chk("reset_count", 32'(bus.rx_count), 32'h0);
    chk("reset_empty", 32'(bus.rx_empty), 32'h1);
    chk("reset_full",  32'(bus.rx_full),  32'h0);
    chk("reset_done",  32'(bus.rx_done),  32'h0);
    chk("reset_drop",  32'(bus.rx_drop),  32'h0);
    chk("reset_head",  {bus.rx_src_out, bus.rx_data_out}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;

    // Basic frame, then drain in order
    send_frame(1'b1, LEN, 16'h0007, 64'hDDDD_CCCC_BBBB_AAAA, 1'b0);
    idle(2);
    drain(20);

    // Truncated frame is dropped, next frame still commits
    send_frame(1'b1, 2, 16'h0011, rand_dat(), 1'b0);
    send_frame(1'b1, LEN, 16'h0012, rand_dat(), 1'b0);
    idle(1);
    // Foreign frame leaves everything untouched
    send_frame(1'b0, LEN, 16'h0013, rand_dat(), 1'b0);
    idle(1);
    drain(20);

    // Fill to full, overflow frame dropped, pop a frame's worth, resend across the wrap
    for (int f = 0; f < DEPTH / LEN; f++) send_frame(1'b1, LEN, 16'(f + 1), rand_dat(), 1'b0);
    send_frame(1'b1, LEN, 16'h0099, rand_dat(), 1'b0);
    idle(1);
    pop_pct = 100;
    repeat (LEN) @(posedge clk);
    pop_pct = 0;
    idle(1);
    send_frame(1'b1, LEN, 16'h0099, rand_dat(), 1'b0);
    idle(1);
    drain(40);

    // Randomized traffic mix
    for (int f = 0; f < 250; f++) begin
      int kind;
      int pcts[4] = '{0, 20, 50, 90};
      pop_pct = pcts[$urandom_range(3)];
      kind = $urandom_range(9);
      if (kind < 6)      send_frame(1'b1, LEN, 16'($urandom), rand_dat(), 1'b0);
      else if (kind < 8) send_frame(1'b1, $urandom_range(LEN - 1), 16'($urandom), rand_dat(), 1'($urandom));
      else               send_frame(1'b0, LEN, 16'($urandom), rand_dat(), 1'b0);
      idle($urandom_range(2));
    end
    idle(2);
    drain(40);

    // Reset in the middle of a frame discards it silently
    mon_en = 1'b0;
    @(posedge clk); #1;
    drive({NODE, 16'h0042});
    drive({NODE, 16'h1111});
    drive({NODE, 16'h2222});
    #2 rst = 1'b0;
    #1;
    chk("midrst_count", 32'(bus.rx_count), 32'h0);
    chk("midrst_empty", 32'(bus.rx_empty), 32'h1);
    chk("midrst_done",  32'(bus.rx_done),  32'h0);
    chk("midrst_drop",  32'(bus.rx_drop),  32'h0);
    chk("midrst_head",  {bus.rx_src_out, bus.rx_data_out}, 32'h0);
    bus.data_rx_packet = 32'h0;
    q.delete();
    pop_pend = 1'b0;
    exp_done = 1'b0;
    exp_drop = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    idle(2);
    send_frame(1'b1, LEN, 16'h0055, rand_dat(), 1'b0);
    idle(2);
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
